muldiv_iter: RTL and testbench

- Iterative RV64M multiply/divide unit instantiated in the execute stage, beside the single-cycle ALU.
- Takes operands from the E-stage pipeline register and computes over many cycles, one bit per cycle.
- Its `stall` output drives the hazard unit's `stallE_mult` input, which freezes the pipeline until the result is ready.
- Result is muxed into the E-stage result path while `out_valid` is high.

---
 rtl/muldiv_iter.sv | 270 +++++++++++++++++++++++++++
 tb/tb_muldiv_iter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative RV64M multiply/divide unit for the execute stage.
// Computes one bit per cycle: radix-2 shift-add for MUL/MULW, restoring
// shift-subtract on magnitudes for DIV/REM variants.
// Optional build macro: MULDIV_EARLY_OUT_EN -- trivial operations (divide by
// zero, signed overflow, zero multiply operand, divisor of one) finish after
// a single BUSY cycle with an identical result.
module muldiv_iter #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            hold,
  input  logic            flush,
  output logic            stall,
  output logic            out_valid,
  output logic [XLEN-1:0] result
);

  localparam logic [3:0] OP_MUL   = 4'd0;
  localparam logic [3:0] OP_MULW  = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_REM   = 4'd4;
  localparam logic [3:0] OP_REMU  = 4'd5;
  localparam logic [3:0] OP_DIVW  = 4'd6;
  localparam logic [3:0] OP_REMW  = 4'd8;
  localparam logic [3:0] OP_REMUW = 4'd9;

  localparam logic [XLEN-1:0] ONE = XLEN'(1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } stateT;

  stateT state, stateNext;

  // Iteration state. accReg is the product accumulator or partial remainder,
  // shReg the multiplier or dividend/quotient shifter, opnReg the
  // multiplicand or divisor.
  logic [6:0]      counter;
  logic [XLEN-1:0] accReg;
  logic [XLEN-1:0] shReg;
  logic [XLEN-1:0] opnReg;
  logic [XLEN-1:0] resultReg;
  logic            mulReg;
  logic            wReg;
  logic            remReg;
  logic            negQReg;
  logic            negRReg;
  logic            earlyReg;

  function automatic logic legalOp(input logic [3:0] o);
    return o <= OP_REMUW;
  endfunction

  function automatic logic isWOp(input logic [3:0] o);
    return (o == OP_MULW) || (o >= OP_DIVW && o <= OP_REMUW);
  endfunction

  function automatic logic isMulOp(input logic [3:0] o);
    return (o == OP_MUL) || (o == OP_MULW);
  endfunction

  function automatic logic isSignedDiv(input logic [3:0] o);
    return (o == OP_DIV) || (o == OP_REM) || (o == OP_DIVW) || (o == OP_REMW);
  endfunction

  function automatic logic isRemOp(input logic [3:0] o);
    return (o == OP_REM) || (o == OP_REMU) || (o == OP_REMW) || (o == OP_REMUW);
  endfunction

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  // W ops only look at the low word, widened according to signedness.
  function automatic logic [XLEN-1:0] condOperand(input logic [XLEN-1:0] v,
                                                  input logic w,
                                                  input logic sgn);
    if (!w)
      return v;
    if (sgn)
      return sext32(v[31:0]);
    return {{(XLEN-32){1'b0}}, v[31:0]};
  endfunction

  // Two's-complement negate when en is set; also used to take magnitudes.
  function automatic logic [XLEN-1:0] negIf(input logic [XLEN-1:0] v, input logic en);
    return en ? (~v + ONE) : v;
  endfunction

  logic                   accept;
  logic                   opW;
  logic                   opMul;
  logic                   opSgn;
  logic                   opRem;
  logic                   signA;
  logic                   signB;
  logic                   bZero;
  logic signed [XLEN-1:0] opA;
  logic signed [XLEN-1:0] opB;
  logic [XLEN-1:0]        magA;
  logic [XLEN-1:0]        magB;
  logic                   earlyHit;
  logic [XLEN-1:0]        earlyVal;

  assign accept = (state == IDLE) && in_valid && !flush && legalOp(op);

  // Decode the incoming op and condition its operands for the accept cycle.
  always_comb begin
    opW   = isWOp(op);
    opMul = isMulOp(op);
    opSgn = isSignedDiv(op);
    opRem = isRemOp(op);
    opA   = condOperand(a, opW, opSgn);
    opB   = condOperand(b, opW, opSgn);
    signA = opSgn & opA[XLEN-1];
    signB = opSgn & opB[XLEN-1];
    magA  = negIf(opA, signA);
    magB  = negIf(opB, signB);
    bZero = (opB == '0);
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic [XLEN-1:0] dividendX;
  logic [XLEN-1:0] minVal;

  // Recognise operations whose answer is known without iterating.
  always_comb begin
    earlyHit  = 1'b0;
    earlyVal  = '0;
    dividendX = opW ? sext32(a[31:0]) : a;
    minVal    = opW ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
    if (opMul) begin
      if (opA == '0 || opB == '0) begin
        earlyHit = 1'b1;
        earlyVal = '0;
      end
    end else if (bZero) begin
      earlyHit = 1'b1;
      earlyVal = opRem ? dividendX : '1;
    end else if (opSgn && opA == minVal && opB == '1) begin
      earlyHit = 1'b1;
      earlyVal = opRem ? '0 : dividendX;
    end else if (opB == ONE) begin
      earlyHit = 1'b1;
      earlyVal = opRem ? '0 : dividendX;
    end
  end
`else
  assign earlyHit = 1'b0;
  assign earlyVal = '0;
`endif

  logic [XLEN-1:0] mulAccNext;
  logic [XLEN:0]   divShift;
  logic [XLEN:0]   divDiff;
  logic            divFits;
  logic [XLEN-1:0] remNext;
  logic [XLEN-1:0] quoNext;
  logic [XLEN-1:0] divSel;
  logic [XLEN-1:0] rawVal;
  logic [XLEN-1:0] finalVal;

  // One multiply or divide step, plus sign fix-up for the final BUSY cycle.
  always_comb begin
    mulAccNext = accReg + (shReg[0] ? opnReg : '0);
    divShift   = {accReg, shReg[XLEN-1]};
    divDiff    = divShift - {1'b0, opnReg};
    divFits    = ~divDiff[XLEN];
    remNext    = divFits ? divDiff[XLEN-1:0] : divShift[XLEN-1:0];
    quoNext    = {shReg[XLEN-2:0], divFits};
    divSel     = remReg ? negIf(remNext, negRReg) : negIf(quoNext, negQReg);
    rawVal     = mulReg ? mulAccNext : divSel;
    finalVal   = wReg ? sext32(rawVal[31:0]) : rawVal;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= stateNext;
  end

  // Next-state and handshake outputs; flush beats accept and hold.
  always_comb begin
    stateNext = state;
    stall     = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          stateNext = BUSY;
          stall     = 1'b1;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (flush)
          stateNext = IDLE;
        else if (counter == 7'd1)
          stateNext = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (flush || !hold)
          stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Operand capture on accept, then one iteration per BUSY cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      counter   <= '0;
      accReg    <= '0;
      shReg     <= '0;
      opnReg    <= '0;
      resultReg <= '0;
      mulReg    <= 1'b0;
      wReg      <= 1'b0;
      remReg    <= 1'b0;
      negQReg   <= 1'b0;
      negRReg   <= 1'b0;
      earlyReg  <= 1'b0;
    end else if (accept) begin
      counter  <= earlyHit ? 7'd1 : (opW ? 7'd32 : 7'd64);
      mulReg   <= opMul;
      wReg     <= opW;
      remReg   <= opRem;
      negQReg  <= (signA ^ signB) & ~bZero;
      negRReg  <= signA;
      earlyReg <= earlyHit;
      accReg   <= '0;
      if (opMul) begin
        // Low product bits do not depend on operand signedness.
        opnReg <= opA;
        shReg  <= opB;
      end else begin
        // A W dividend sits in the top word so the MSB feed is always XLEN-1.
        opnReg <= magB;
        shReg  <= opW ? {magA[XLEN-33:0], 32'b0} : magA;
      end
      if (earlyHit)
        resultReg <= earlyVal;
    end else if (state == BUSY && !flush) begin
      counter <= counter - 7'd1;
      if (mulReg) begin
        accReg <= mulAccNext;
        opnReg <= {opnReg[XLEN-2:0], 1'b0};
        shReg  <= {1'b0, shReg[XLEN-1:1]};
      end else begin
        accReg <= remNext;
        shReg  <= quoNext;
      end
      if (counter == 7'd1 && !earlyReg)
        resultReg <= finalVal;
    end
  end

  assign result = resultReg;

endmodule

// File: tb/tb_muldiv_iter.sv
// tb_muldiv_iter: directed vectors with a result/latency scoreboard.
module tb_muldiv_iter;

  localparam logic [3:0] MUL = 4'd0, MULW = 4'd1, DIV = 4'd2, DIVU = 4'd3,
                         REM = 4'd4, REMU = 4'd5, DIVW = 4'd6, DIVUW = 4'd7,
                         REMW = 4'd8, REMUW = 4'd9;

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  localparam int L64 = 65;
  localparam int L32 = 33;
  localparam int E64 = EARLY ? 2 : 65;
  localparam int E32 = EARLY ? 2 : 33;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inValid = 1'b0;
  logic [3:0]  opIn = 4'd0;
  logic [63:0] aIn = '0;
  logic [63:0] bIn = '0;
  logic        hold = 1'b0;
  logic        flush = 1'b0;
  logic        stall;
  logic        outValid;
  logic [63:0] result;

  typedef struct {
    logic [63:0] res;
    int          lat;
  } expT;

  expT expQ[$];
  int  nChecks = 0;
  int  nFail = 0;

  muldiv_iter #(.XLEN(64)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(inValid),
    .op(opIn),
    .a(aIn),
    .b(bIn),
    .hold(hold),
    .flush(flush),
    .stall(stall),
    .out_valid(outValid),
    .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: counts stall cycles and checks each presented result.
  initial begin
    int   stallCnt;
    logic prevValid;
    expT  cur;
    stallCnt  = 0;
    prevValid = 1'b0;
    cur.res   = '0;
    cur.lat   = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stallCnt  = 0;
        prevValid = 1'b0;
      end else begin
        if (outValid) begin
          if (!prevValid) begin
            if (expQ.size() == 0) begin
              check("unexpected_out_valid", 64'(outValid), 64'd0);
            end else begin
              cur = expQ.pop_front();
              check("result", result, cur.res);
              check("stall_cycles", 64'(stallCnt), 64'(cur.lat));
              check("stall_in_done", 64'(stall), 64'd0);
            end
          end else begin
            check("hold_result_stable", result, cur.res);
            check("hold_no_reaccept", 64'(stall), 64'd0);
          end
          stallCnt = 0;
        end else if (stall) begin
          stallCnt++;
        end else begin
          stallCnt = 0;
        end
        prevValid = outValid;
      end
    end
  end

  task automatic runOp(input logic [3:0] o, input logic [63:0] av, input logic [63:0] bv,
                       input logic [63:0] expRes, input int expLat, input int holdCycles);
    bit got;
    expT e;
    e.res = expRes;
    e.lat = expLat;
    expQ.push_back(e);
    inValid = 1'b1;
    opIn    = o;
    aIn     = av;
    bIn     = bv;
    got     = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (outValid) begin
        got = 1'b1;
        break;
      end
    end
    check("done_reached", 64'(got), 64'd1);
    if (holdCycles > 0) begin
      hold = 1'b1;
      for (int k = 1; k < holdCycles; k++) begin
        @(posedge clk);
        #1;
      end
      @(posedge clk);
      #1;
      check("still_done_after_hold", 64'(outValid), 64'd1);
    end
    hold    = 1'b0;
    inValid = 1'b0;
    @(posedge clk);
    #1;
    check("idle_out_valid", 64'(outValid), 64'd0);
    check("idle_stall", 64'(stall), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_stall", 64'(stall), 64'd0);
    check("reset_out_valid", 64'(outValid), 64'd0);
    check("reset_result", result, 64'd0);

    runOp(MUL,   64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, L64, 0);
    runOp(DIVW,  64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, E32, 0);
    runOp(REMU,  64'd100, 64'd0, 64'd100, E64, 0);
    runOp(DIVU,  64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, E64, 0);
    runOp(REM,   -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, L64, 0);
    runOp(DIV,   -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, L64, 0);
    runOp(DIV,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, E64, 0);
    runOp(REMW,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, L32, 0);
    runOp(MULW,  64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, L32, 0);
    runOp(DIVUW, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, E32, 0);
    runOp(REMUW, 64'h0000_0000_8000_0005, 64'd0, 64'hFFFF_FFFF_8000_0005, E32, 0);
    runOp(MUL,   64'd0, 64'd12345, 64'd0, E64, 0);
    runOp(DIVUW, 64'hDEAD_BEEF_0000_0064, 64'h1234_5678_0000_0007, 64'd14, L32, 0);
    runOp(DIVU,  64'd1000, 64'd7, 64'd142, L64, 3);

    // Illegal op is ignored.
    inValid = 1'b1;
    opIn    = 4'd12;
    aIn     = 64'd5;
    bIn     = 64'd6;
    #1;
    check("illegal_stall", 64'(stall), 64'd0);
    @(posedge clk);
    #1;
    check("illegal_not_busy", 64'(stall), 64'd0);

    // Flush together with a legal op in IDLE accepts nothing.
    opIn  = MUL;
    flush = 1'b1;
    #1;
    check("flush_accept_stall", 64'(stall), 64'd0);
    @(posedge clk);
    #1;
    flush   = 1'b0;
    inValid = 1'b0;
    #1;
    check("flush_accept_not_busy", 64'(stall), 64'd0);

    // Flush a DIV in its tenth BUSY cycle.
    inValid = 1'b1;
    opIn    = DIV;
    aIn     = 64'd1000;
    bIn     = 64'd7;
    repeat (10) @(posedge clk);
    #1;
    check("busy_before_flush", 64'(stall), 64'd1);
    flush   = 1'b1;
    inValid = 1'b0;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_stall", 64'(stall), 64'd0);
    check("flush_out_valid", 64'(outValid), 64'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("flush_stays_idle", 64'(outValid), 64'd0);
    end

    runOp(MULW, 64'd3, 64'd4, 64'd12, L32, 0);

    // Reset in the middle of an operation clears everything.
    inValid = 1'b1;
    opIn    = MUL;
    aIn     = 64'd9;
    bIn     = 64'd9;
    repeat (5) @(posedge clk);
    #1;
    reset   = 1'b1;
    inValid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midreset_stall", 64'(stall), 64'd0);
    check("midreset_out_valid", 64'(outValid), 64'd0);
    check("midreset_result", result, 64'd0);

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(expQ.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
    $finish;
  end

endmodule
